// File: rtl/ts_sched_pkg.sv
// Shared constants and state encoding for the TS split-path 32->8 byte scheduler.
// Also holds the byte-shift helper used by the serializer.
package ts_sched_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Moves the next byte into the MSB position, zero-filling the bottom.
    function automatic logic [WORD_W-1:0] shift_byte(input logic [WORD_W-1:0] w);
        return {w[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ts_word_fifo.sv
// DEPTH x 32-bit first-word-fall-through FIFO for one scheduler channel.
// A push while full is taken when a pop happens on the same edge.
module ts_word_fifo
    import ts_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ts_32_8_rr_sched.sv
// Shares one 32->8 byte serializer among NUM_CH buffered word streams, granting
// round-robin and emitting a byte stream tagged with channel id and start-of-word.
module ts_32_8_rr_sched
    import ts_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2,
    parameter int CHW    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*WORD_W-1:0] din_32bit,
    input  logic [NUM_CH-1:0]        din_32bit_en,
    output logic [BYTE_W-1:0]        dout_8bit,
    output logic                     dout_8bit_en,
    output logic [CHW-1:0]           dout_ch,
    output logic                     dout_sof,
    output logic [NUM_CH-1:0]        buf_full,
    output logic [NUM_CH-1:0]        ovf
);

    logic [WORD_W-1:0] fifo_rdata [NUM_CH];
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] pop_vec;

    state_t            state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CHW-1:0]    rr_ptr;
    logic [WORD_W-1:0] shift_p0;

    logic              gnt_vld;
    logic [CHW-1:0]    gnt_idx;
    logic              last_byte;
    logic              can_grant;
    logic              gnt_fire;
    logic [WORD_W-1:0] sel_word;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
        ts_word_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (din_32bit_en[gi]),
            .wdata (din_32bit[gi*WORD_W +: WORD_W]),
            .pop   (pop_vec[gi]),
            .rdata (fifo_rdata[gi]),
            .full  (buf_full[gi]),
            .empty (fifo_empty[gi])
        );
    end

    // Round-robin search starting just after the last grant; scanning from the
    // far end down lets the nearest non-empty channel win.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!fifo_empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
    end

    assign last_byte = (state == ST_SEND) && (byte_cnt == CNT_W'(BYTES_PER_WORD-1));
    assign can_grant = (state == ST_IDLE) || last_byte;
    assign gnt_fire  = can_grant && gnt_vld;
    assign sel_word  = fifo_rdata[gnt_idx];

    always_comb begin
        pop_vec = '0;
        if (gnt_fire) pop_vec[gnt_idx] = 1'b1;
    end

    // Control and output stage: arbitration, byte counter, registered byte lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            rr_ptr       <= CHW'(NUM_CH-1);
            dout_8bit    <= '0;
            dout_8bit_en <= 1'b0;
            dout_ch      <= '0;
            dout_sof     <= 1'b0;
            ovf          <= '0;
        end else begin
            ovf <= din_32bit_en & buf_full & ~pop_vec;
            if (gnt_fire) begin
                state        <= ST_SEND;
                byte_cnt     <= '0;
                rr_ptr       <= gnt_idx;
                dout_8bit    <= sel_word[WORD_W-1 -: BYTE_W];
                dout_8bit_en <= 1'b1;
                dout_ch      <= gnt_idx;
                dout_sof     <= 1'b1;
            end else if (can_grant) begin
                state        <= ST_IDLE;
                byte_cnt     <= '0;
                dout_8bit    <= '0;
                dout_8bit_en <= 1'b0;
                dout_ch      <= '0;
                dout_sof     <= 1'b0;
            end else begin
                byte_cnt     <= byte_cnt + 1'b1;
                dout_8bit    <= shift_p0[WORD_W-1 -: BYTE_W];
                dout_sof     <= 1'b0;
            end
        end
    end

    // Shift register holds the not-yet-sent bytes of the granted word.
    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            shift_p0 <= shift_byte(sel_word);
        end else if (state == ST_SEND) begin
            shift_p0 <= shift_byte(shift_p0);
        end
    end

endmodule

// File: tb/tb_ts_32_8_rr_sched.sv
// Bench for ts_32_8_rr_sched: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based model of the scheduler.
module tb_ts_32_8_rr_sched;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 2;
    localparam int CHW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CH*32-1:0]  din_32bit;
    logic [NUM_CH-1:0]     din_32bit_en;
    logic [7:0]            dout_8bit;
    logic                  dout_8bit_en;
    logic [CHW-1:0]        dout_ch;
    logic                  dout_sof;
    logic [NUM_CH-1:0]     buf_full;
    logic [NUM_CH-1:0]     ovf;

    always #5 clk = ~clk;

    ts_32_8_rr_sched #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CHW(CHW)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_32bit    (din_32bit),
        .din_32bit_en (din_32bit_en),
        .dout_8bit    (dout_8bit),
        .dout_8bit_en (dout_8bit_en),
        .dout_ch      (dout_ch),
        .dout_sof     (dout_sof),
        .buf_full     (buf_full),
        .ovf          (ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-channel word queues and the word being serialized.
    logic [31:0]       q [NUM_CH][$];
    bit                m_idle;
    logic [31:0]       m_word;
    int                m_ch;
    int                m_pos;
    int                m_rr;
    logic [NUM_CH-1:0] m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) q[k].delete();
        m_idle = 1'b1;
        m_word = '0;
        m_ch   = 0;
        m_pos  = 0;
        m_rr   = NUM_CH - 1;
        m_ovf  = '0;
    endtask

    task automatic model_edge();
        int  pre [NUM_CH];
        bit  can;
        int  popk;
        for (int k = 0; k < NUM_CH; k++) pre[k] = q[k].size();
        can  = m_idle || (m_pos == 3);
        popk = -1;
        if (can) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                int c;
                c = (m_rr + i) % NUM_CH;
                if (popk < 0 && pre[c] > 0) popk = c;
            end
        end
        if (popk >= 0) begin
            m_word = q[popk].pop_front();
            m_ch   = popk;
            m_rr   = popk;
            m_pos  = 0;
            m_idle = 1'b0;
        end else if (can) begin
            m_idle = 1'b1;
        end else begin
            m_pos++;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            m_ovf[k] = 1'b0;
            if (din_32bit_en[k]) begin
                if (pre[k] < DEPTH || popk == k) q[k].push_back(din_32bit[k*32 +: 32]);
                else m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic check_outs();
        logic [7:0]        e_byte;
        logic [NUM_CH-1:0] e_full;
        e_byte = m_idle ? 8'h00 : 8'((m_word >> (8 * (3 - m_pos))) & 32'hFF);
        for (int k = 0; k < NUM_CH; k++) e_full[k] = (q[k].size() == DEPTH);
        chk("dout_8bit_en", 32'(dout_8bit_en), 32'(!m_idle));
        chk("dout_8bit",    32'(dout_8bit),    32'(e_byte));
        chk("dout_ch",      32'(dout_ch),      m_idle ? 32'd0 : 32'(m_ch));
        chk("dout_sof",     32'(dout_sof),     32'(!m_idle && m_pos == 0));
        chk("buf_full",     32'(buf_full),     32'(e_full));
        chk("ovf",          32'(ovf),          32'(m_ovf));
    endtask

    function automatic logic [NUM_CH*32-1:0] put(input logic [NUM_CH*32-1:0] d,
                                                 input int k, input logic [31:0] w);
        logic [NUM_CH*32-1:0] r;
        r = d;
        r[k*32 +: 32] = w;
        return r;
    endfunction

    task automatic cycle(input logic [NUM_CH-1:0] en, input logic [NUM_CH*32-1:0] d);
        din_32bit_en = en;
        din_32bit    = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        din_32bit_en = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din_32bit_en = '0;
        din_32bit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [NUM_CH*32-1:0] d;
        logic [NUM_CH-1:0]    en;
        int                   dens;

        // 1: single word on ch0
        do_reset();
        cycle(4'b0001, put('0, 0, 32'h47112233));
        idle(7);

        // 2: ch0 and ch2 on the same edge
        d = put('0, 0, 32'hA0A1A2A3);
        d = put(d, 2, 32'hC0C1C2C3);
        cycle(4'b0101, d);
        idle(10);

        // 3: every channel backlogged with two words
        do_reset();
        d = '0;
        for (int k = 0; k < NUM_CH; k++) d = put(d, k, 32'h10101010 * (k + 1));
        cycle(4'b1111, d);
        for (int k = 0; k < NUM_CH; k++) d = put(d, k, 32'h01020304 + 32'h11000000 * k);
        cycle(4'b1111, d);
        idle(36);

        // 4: ch1 pushed every cycle for 12 cycles
        for (int i = 0; i < 12; i++) cycle(4'b0010, put('0, 1, 32'hB1000000 + 32'(i)));
        idle(20);

        // 5: ch3 full and popped on the same edge as a new write
        cycle(4'b0001, put('0, 0, 32'h0D0D0D0D));
        cycle(4'b1000, put('0, 3, 32'h33330001));
        cycle(4'b1000, put('0, 3, 32'h33330002));
        idle(2);
        cycle(4'b1000, put('0, 3, 32'h33330003));
        idle(16);

        // 6: asynchronous reset during byte 2 of a word
        cycle(4'b0011, put(put('0, 0, 32'hDEADBEEF), 1, 32'h12345678));
        idle(3);
        #1 rst = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        cycle(4'b0001, put('0, 0, 32'h5A5B5C5D));
        idle(6);

        // Randomized traffic with varying load
        for (int blk = 0; blk < 10; blk++) begin
            dens = int'($urandom_range(0, 4));
            for (int i = 0; i < 80; i++) begin
                en = '0;
                d  = '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    en[k] = ($urandom_range(0, 15) < 32'(dens * 2));
                    d = put(d, k, $urandom);
                end
                cycle(en, d);
            end
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
